// File: rtl/dsp_be_pkg.sv
// Shared types for the BERT measurement controller.
// State encoding, error codes and PRBS instance selects.
package dsp_be_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOCK,
        ST_COUNT,
        ST_SETTLE,
        ST_SUM,
        ST_DONE
    } bert_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2,
        ERR_BAD_SEL = 2'd3
    } bert_err_e;

    localparam logic [1:0] PRBS_SEL_7    = 2'd0;
    localparam logic [1:0] PRBS_SEL_15   = 2'd1;
    localparam logic [1:0] PRBS_SEL_31   = 2'd2;
    localparam logic [1:0] PRBS_SEL_RSVD = 2'd3;

    // Reserved select decodes to no instance at all.
    function automatic logic [2:0] prbs_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            PRBS_SEL_7:  oh = 3'b001;
            PRBS_SEL_15: oh = 3'b010;
            PRBS_SEL_31: oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bert_err_sum.sv
// Combinational masked sum of per-way BERT error counts.
// Result is widened by clog2(Ways) bits so it can never overflow.
module bert_err_sum #(
    parameter int Ways          = 16,
    parameter int BerCountWidth = 41
) (
    input  logic [Ways*BerCountWidth-1:0]          i_counts,
    input  logic [Ways-1:0]                        i_mask,
    output logic [BerCountWidth+$clog2(Ways)-1:0]  o_sum
);

    localparam int SumWidth = BerCountWidth + $clog2(Ways);

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < Ways; i++) begin
            if (i_mask[i]) begin
                o_sum = o_sum
                      + SumWidth'(i_counts[i*BerCountWidth +: BerCountWidth]);
            end
        end
    end

endmodule

// File: rtl/dsp_be_bert_ctrl.sv
// BERT run sequencer: clear, lock, count, settle, sum, report.
// Optional lock timeout enabled by DSP_BE_BERT_CTRL_LOCK_TIMEOUT_EN.
module dsp_be_bert_ctrl
    import dsp_be_pkg::*;
#(
    parameter int Ways          = 16,
    parameter int BerCountWidth = 41,
    parameter int TimeoutWidth  = 16,
    parameter int ClrCycles     = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic                                  i_abort,
    input  logic [1:0]                            i_cfg_prbs_sel,
    input  logic [Ways-1:0]                       i_cfg_way_mask,
    input  logic [TimeoutWidth-1:0]               i_cfg_lock_timeout,
    input  logic [Ways-1:0]                       i_seed_good_prbs7,
    input  logic [Ways-1:0]                       i_seed_good_prbs15,
    input  logic [Ways-1:0]                       i_seed_good_prbs31,
    input  logic                                  i_shutoff_prbs7,
    input  logic                                  i_shutoff_prbs15,
    input  logic                                  i_shutoff_prbs31,
    input  logic [Ways*BerCountWidth-1:0]         i_ber_count_prbs7,
    input  logic [Ways*BerCountWidth-1:0]         i_ber_count_prbs15,
    input  logic [Ways*BerCountWidth-1:0]         i_ber_count_prbs31,
    input  logic [BerCountWidth-1:0]              i_bit_count_prbs7,
    input  logic [BerCountWidth-1:0]              i_bit_count_prbs15,
    input  logic [BerCountWidth-1:0]              i_bit_count_prbs31,
    output logic [2:0]                            o_bert_rst,
    output logic [Ways-1:0]                       o_ber_count_en,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [1:0]                            o_err,
    output logic [BerCountWidth+$clog2(Ways)-1:0] o_err_sum,
    output logic [BerCountWidth-1:0]              o_bit_total
);

    localparam int SumWidth = BerCountWidth + $clog2(Ways);
    localparam int ClrW     = (ClrCycles > 1) ? $clog2(ClrCycles) : 1;
    localparam logic [ClrW-1:0] ClrLast = ClrW'(ClrCycles - 1);

    bert_state_e state_q, state_d;
    bert_err_e   err_q, err_d;

    logic [1:0]               sel_q;
    logic [Ways-1:0]          mask_q;
    logic [ClrW-1:0]          clr_q;
    logic                     settle_q;
    logic [SumWidth-1:0]      sum_q;
    logic [BerCountWidth-1:0] bits_q;

    logic [Ways-1:0]               seed_sel;
    logic                          shut_sel;
    logic [Ways*BerCountWidth-1:0] ber_sel;
    logic [BerCountWidth-1:0]      bit_sel;
    logic [SumWidth-1:0]           sum_w;
    logic                          lock_ok;
    logic                          timeout_hit;
    logic                          bad_cfg;

    always_comb begin
        seed_sel = '0;
        shut_sel = 1'b0;
        ber_sel  = '0;
        bit_sel  = '0;
        case (sel_q)
            PRBS_SEL_7: begin
                seed_sel = i_seed_good_prbs7;
                shut_sel = i_shutoff_prbs7;
                ber_sel  = i_ber_count_prbs7;
                bit_sel  = i_bit_count_prbs7;
            end
            PRBS_SEL_15: begin
                seed_sel = i_seed_good_prbs15;
                shut_sel = i_shutoff_prbs15;
                ber_sel  = i_ber_count_prbs15;
                bit_sel  = i_bit_count_prbs15;
            end
            PRBS_SEL_31: begin
                seed_sel = i_seed_good_prbs31;
                shut_sel = i_shutoff_prbs31;
                ber_sel  = i_ber_count_prbs31;
                bit_sel  = i_bit_count_prbs31;
            end
            default: ;
        endcase
    end

    assign lock_ok = (seed_sel & mask_q) == mask_q;
    assign bad_cfg = (i_cfg_prbs_sel == PRBS_SEL_RSVD)
                   || (i_cfg_way_mask == '0);

    bert_err_sum #(
        .Ways          (Ways),
        .BerCountWidth (BerCountWidth)
    ) u_err_sum (
        .i_counts (ber_sel),
        .i_mask   (mask_q),
        .o_sum    (sum_w)
    );

`ifdef DSP_BE_BERT_CTRL_LOCK_TIMEOUT_EN
    logic [TimeoutWidth-1:0] to_q;

    // LOCK lasts at most i_cfg_lock_timeout cycles; zero disables it.
    assign timeout_hit = (i_cfg_lock_timeout != '0)
                       && (to_q == i_cfg_lock_timeout - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_q <= '0;
        end else if (state_q == ST_LOCK) begin
            to_q <= to_q + 1'b1;
        end else begin
            to_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^i_cfg_lock_timeout;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && bad_cfg) begin
                    state_d = ST_DONE;
                    err_d   = ERR_BAD_SEL;
                end else if (i_start) begin
                    state_d = ST_CLEAR;
                    err_d   = ERR_OK;
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_d = ST_SETTLE;
                    err_d   = ERR_ABORT;
                end else if (clr_q == ClrLast) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (i_abort) begin
                    state_d = ST_SETTLE;
                    err_d   = ERR_ABORT;
                end else if (lock_ok) begin
                    state_d = ST_COUNT;
                end else if (timeout_hit) begin
                    state_d = ST_SETTLE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_COUNT: begin
                if (i_abort) begin
                    state_d = ST_SETTLE;
                    err_d   = ERR_ABORT;
                end else if (shut_sel) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q) state_d = ST_SUM;
            end
            ST_SUM:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q    <= ERR_OK;
            sel_q    <= '0;
            mask_q   <= '0;
            clr_q    <= '0;
            settle_q <= 1'b0;
            sum_q    <= '0;
            bits_q   <= '0;
        end else begin
            err_q    <= err_d;
            clr_q    <= (state_q == ST_CLEAR) ? clr_q + 1'b1 : '0;
            settle_q <= (state_q == ST_SETTLE) && !settle_q;
            if (state_q == ST_IDLE && i_start) begin
                sel_q  <= i_cfg_prbs_sel;
                mask_q <= i_cfg_way_mask;
            end
            if (state_q == ST_SUM) begin
                sum_q  <= sum_w;
                bits_q <= bit_sel;
            end
        end
    end

    always_comb begin
        o_busy         = state_q != ST_IDLE;
        o_done         = state_q == ST_DONE;
        o_bert_rst     = 3'b000;
        o_ber_count_en = '0;
        if (state_q == ST_CLEAR) o_bert_rst = prbs_onehot(sel_q);
        if (state_q == ST_COUNT) o_ber_count_en = mask_q;
    end

    assign o_err       = err_q;
    assign o_err_sum   = sum_q;
    assign o_bit_total = bits_q;

endmodule

// File: tb/tb_dsp_be_bert_ctrl.sv
// Bench for dsp_be_bert_ctrl: vector table plus result scoreboard.
// Define DSP_BE_BERT_CTRL_LOCK_TIMEOUT_EN to also exercise the timeout.
module tb_dsp_be_bert_ctrl;

    localparam int W  = 16;
    localparam int BW = 41;
    localparam int SW = BW + $clog2(W);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [1:0]      cfg_sel;
    logic [W-1:0]    cfg_mask;
    logic [15:0]     cfg_to;
    logic [W-1:0]    seed7, seed15, seed31;
    logic            shut7, shut15, shut31;
    logic [W*BW-1:0] ber7, ber15, ber31;
    logic [BW-1:0]   bit7, bit15, bit31;
    logic [2:0]      bert_rst;
    logic [W-1:0]    cnt_en;
    logic            busy;
    logic            done;
    logic [1:0]      err;
    logic [SW-1:0]   err_sum;
    logic [BW-1:0]   bit_total;

    dsp_be_bert_ctrl dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_abort            (abort),
        .i_cfg_prbs_sel     (cfg_sel),
        .i_cfg_way_mask     (cfg_mask),
        .i_cfg_lock_timeout (cfg_to),
        .i_seed_good_prbs7  (seed7),
        .i_seed_good_prbs15 (seed15),
        .i_seed_good_prbs31 (seed31),
        .i_shutoff_prbs7    (shut7),
        .i_shutoff_prbs15   (shut15),
        .i_shutoff_prbs31   (shut31),
        .i_ber_count_prbs7  (ber7),
        .i_ber_count_prbs15 (ber15),
        .i_ber_count_prbs31 (ber31),
        .i_bit_count_prbs7  (bit7),
        .i_bit_count_prbs15 (bit15),
        .i_bit_count_prbs31 (bit31),
        .o_bert_rst         (bert_rst),
        .o_ber_count_en     (cnt_en),
        .o_busy             (busy),
        .o_done             (done),
        .o_err              (err),
        .o_err_sum          (err_sum),
        .o_bit_total        (bit_total)
    );

    always #5 clk = ~clk;

    // mode: 0 shutoff, 1 abort+shutoff same cycle, 2 abort in LOCK, 3 timeout
    typedef struct {
        logic [1:0]    sel;
        logic [W-1:0]  mask;
        int            lock_dly;
        int            cnt_len;
        int            mode;
        logic [1:0]    exp_err;
        logic [SW-1:0] exp_sum;
        logic [BW-1:0] exp_bits;
    } vec_t;

    typedef struct {
        logic [1:0]    err;
        logic [SW-1:0] sum;
        logic [BW-1:0] bits;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    function automatic logic [BW-1:0] way_val(input int i);
        if (i == 0) return 41'd5;
        if (i == 1) return 41'd7;
        if (i == 2) return 41'd100;
        return BW'(i * 1000);
    endfunction

    task automatic set_counts(input logic [1:0] s);
        logic [W*BW-1:0] good, other;
        for (int i = 0; i < W; i++) begin
            good[i*BW +: BW]  = way_val(i);
            other[i*BW +: BW] = 41'd77;
        end
        ber7  = (s == 2'd0) ? good : other;
        ber15 = (s == 2'd1) ? good : other;
        ber31 = (s == 2'd2) ? good : other;
        bit7  = (s == 2'd0) ? 41'd1111 : 41'd9999;
        bit15 = (s == 2'd1) ? 41'd2222 : 41'd9999;
        bit31 = (s == 2'd2) ? 41'd3333 : 41'd9999;
    endtask

    task automatic drive_sel(input logic [1:0] s, input logic sd,
                             input logic sh);
        seed7  = (s == 2'd0 && sd) ? '1 : '0;
        seed15 = (s == 2'd1 && sd) ? '1 : '0;
        seed31 = (s == 2'd2 && sd) ? '1 : '0;
        shut7  = (s == 2'd0) && sh;
        shut15 = (s == 2'd1) && sh;
        shut31 = (s == 2'd2) && sh;
    endtask

    task automatic run(input vec_t v, input string tag);
        exp_t e;
        logic [2:0] exp_oh;
        logic good_cfg;
        int rst_cyc = 0, cnt_cyc = 0, lock_cnt = 0, done_cyc = 0;
        bit rst_bad = 0, en_bad = 0, busy_bad = 0;
        bit in_lock = 0, done_seen = 0, shut = 0, seed = 0;

        good_cfg = (v.sel != 2'd3) && (v.mask != '0);
        exp_oh   = (v.sel == 2'd3) ? 3'b000 : 3'(1 << v.sel);
        set_counts(v.sel);
        drive_sel(v.sel, 1'b0, 1'b0);
        cfg_sel  = v.sel;
        cfg_mask = v.mask;
        sb.push_back('{v.exp_err, v.exp_sum, v.exp_bits});
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cfg_sel  = 2'd3;
        cfg_mask = ~v.mask;
        for (int cyc = 1; cyc <= 600 && !done_seen; cyc++) begin
            abort = 1'b0;
            start = 1'b0;
            if (!busy) busy_bad = 1;
            if (bert_rst != 3'b000) begin
                rst_cyc++;
                if (bert_rst !== exp_oh) rst_bad = 1;
            end else if (rst_cyc > 0) begin
                in_lock = 1;
            end
            if (in_lock) lock_cnt++;
            if (cnt_en != '0) begin
                if (cnt_en === v.mask) cnt_cyc++;
                else en_bad = 1;
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_err"}, err, e.err);
                    chk({tag, "_sum"}, err_sum, e.sum);
                    chk({tag, "_bits"}, bit_total, e.bits);
                end
            end else begin
                if (in_lock && lock_cnt == v.lock_dly) seed = 1;
                if (v.mode == 2 && in_lock && lock_cnt == 5) abort = 1'b1;
                if (in_lock && lock_cnt == 2) start = 1'b1;
                if (v.cnt_len > 0 && cnt_cyc == v.cnt_len && !shut) begin
                    shut = 1;
                    if (v.mode == 1) abort = 1'b1;
                end
                drive_sel(v.sel, seed, shut);
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        drive_sel(v.sel, 1'b0, 1'b0);
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
        chk({tag, "_busy_held"}, busy_bad, 0);
        chk({tag, "_clr_cycles"}, rst_cyc, good_cfg ? 4 : 0);
        chk({tag, "_clr_onehot"}, rst_bad, 0);
        chk({tag, "_en_value"}, en_bad, 0);
        chk({tag, "_en_cycles"}, cnt_cyc,
            (v.mode <= 1 && good_cfg) ? v.cnt_len : 0);
        if (!good_cfg) chk({tag, "_badsel_latency"}, done_cyc <= 2, 1);
        if (v.mode == 3)
            chk({tag, "_timeout_latency"},
                lock_cnt >= 22 && lock_cnt <= 26, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bert_rst"}, bert_rst, 0);
        chk({tag, "_cnt_en"}, cnt_en, 0);
        chk({tag, "_busy_done"}, {busy, done}, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_sum"}, err_sum, 0);
        chk({tag, "_bit_total"}, bit_total, 0);
    endtask

    initial begin
        vec_t tv;
        bit seen, done_bad;
        vecs[0] = '{2'd1, 16'hFFFF, 10, 100, 0, 2'd0, 45'd117112, 41'd2222};
        vecs[1] = '{2'd0, 16'h0003, 3, 5, 0, 2'd0, 45'd12, 41'd1111};
        vecs[2] = '{2'd2, 16'h0004, 1, 7, 0, 2'd0, 45'd100, 41'd3333};
        vecs[3] = '{2'd2, 16'h8001, 4, 8, 1, 2'd2, 45'd15005, 41'd3333};
        vecs[4] = '{2'd3, 16'hFFFF, 1, 0, 0, 2'd3, 45'd15005, 41'd3333};
        vecs[5] = '{2'd0, 16'h0000, 1, 0, 0, 2'd3, 45'd15005, 41'd3333};
        vecs[6] = '{2'd1, 16'h00F0, 1000, 0, 2, 2'd2, 45'd22000, 41'd2222};

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        cfg_sel  = 2'd0;
        cfg_mask = '0;
        cfg_to   = 16'd20;
        set_counts(2'd0);
        drive_sel(2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        abort = 1'b1;
        done_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) done_bad = 1;
        end
        abort = 1'b0;
        chk("idle_abort_ignored", done_bad, 0);

        for (int i = 0; i < 7; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        tv = '{2'd1, 16'hFFFF, 2, 0, 0, 2'd0, 45'd0, 41'd0};
        set_counts(tv.sel);
        cfg_sel  = tv.sel;
        cfg_mask = tv.mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bert_rst == 3'b000 && busy) drive_sel(tv.sel, 1'b1, 1'b0);
            if (cnt_en != '0) seen = 1;
        end
        chk("rst_run_reached_count", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        rst = 1'b0;
        drive_sel(tv.sel, 1'b0, 1'b0);
        done_bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) done_bad = 1;
        end
        chk("midrun_reset_no_done", done_bad, 0);

`ifdef DSP_BE_BERT_CTRL_LOCK_TIMEOUT_EN
        tv = '{2'd0, 16'h0001, 1000, 0, 3, 2'd1, 45'd5, 41'd1111};
        run(tv, "timeout");
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
